afifo_rd_drain: RTL

Read-side consumer for the asynchronous FIFO. It runs entirely in the read clock domain. It pops words from the FIFO read port (rd_data/rd_empty/rd_inc) and presents them on a registered valid/ready stream through a 2-entry buffer. It also supports a flush mode that drains and discards FIFO contents, and keeps delivered and dropped word counters.

---
 rtl/afifo_rd_drain_pkg.sv | 9 +
 rtl/afifo_rd_drain_if.sv | 11 +
 rtl/afifo_rd_drain_chk.sv | 11 +
 rtl/afifo_skid_buf.sv | 78 +++++++
 rtl/afifo_rd_drain.sv | 102 ++++++++++
 5 files changed

// File: rtl/afifo_rd_drain_pkg.sv
// Shared types and constants for the async-FIFO read-side drain block.
package afifo_rd_drain_pkg;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} afifo_drain_state_e;

  localparam int DRAIN_BUF_DEPTH = 2;
  localparam int BUF_CNT_W       = 2;

endpackage

// File: rtl/afifo_rd_drain_if.sv
// Output valid/ready stream of the drain block.
interface afifo_rd_drain_if #(parameter int DSIZE = 8);

  logic             m_valid;
  logic [DSIZE-1:0] m_data;
  logic             m_ready;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/afifo_rd_drain_chk.sv
// Protocol checker: the FIFO must never be popped while empty.
module afifo_rd_drain_chk (
  input logic clk,
  input logic rst_n,
  input logic rd_inc,
  input logic rd_empty
);

  a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!rst_n) !(rd_inc && rd_empty));

endmodule

// File: rtl/afifo_skid_buf.sv
// Two-entry head/skid buffer with registered valid and head data.
module afifo_skid_buf
  import afifo_rd_drain_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [DSIZE-1:0]     push_data,
  input  logic                 pop,
  input  logic                 clear,
  output logic                 valid,
  output logic [DSIZE-1:0]     head,
  output logic [BUF_CNT_W-1:0] count
);

  logic [BUF_CNT_W-1:0] count_r, count_n_s;
  logic [DSIZE-1:0]     head_r, head_n_s, skid_r, skid_n_s;
  logic                 valid_r;

  // next-entry selection for push/pop/clear combinations
  always_comb begin
    count_n_s = count_r;
    head_n_s  = head_r;
    skid_n_s  = skid_r;
    if (clear) begin
      count_n_s = {BUF_CNT_W{1'b0}};
    end else begin
      case ({push, pop})
        2'b11: begin
          // pop implies count>=1; with one entry the new word goes straight to head
          if (count_r == 2'd1) begin
            head_n_s = push_data;
          end else begin
            head_n_s = skid_r;
            skid_n_s = push_data;
          end
        end
        2'b10: begin
          if (count_r == 2'd0) begin
            head_n_s = push_data;
          end else begin
            skid_n_s = push_data;
          end
          count_n_s = count_r + 2'd1;
        end
        2'b01: begin
          head_n_s  = skid_r;
          count_n_s = count_r - 2'd1;
        end
        default: begin
          count_n_s = count_r;
        end
      endcase
    end
  end

  // storage and registered valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {BUF_CNT_W{1'b0}};
      head_r  <= {DSIZE{1'b0}};
      skid_r  <= {DSIZE{1'b0}};
      valid_r <= 1'b0;
    end else begin
      count_r <= count_n_s;
      head_r  <= head_n_s;
      skid_r  <= skid_n_s;
      valid_r <= (count_n_s != 2'd0);
    end
  end

  assign valid = valid_r;
  assign head  = head_r;
  assign count = count_r;

endmodule

// File: rtl/afifo_rd_drain.sv
// Read-domain FIFO consumer: pops into a skid buffer, streams out, and drains on flush.
module afifo_rd_drain
  import afifo_rd_drain_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int CNT_W = 16
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic [DSIZE-1:0]  rd_data,
  input  logic              rd_empty,
  output logic              rd_inc,
  afifo_rd_drain_if.master  m,
  input  logic              flush,
  output logic [CNT_W-1:0]  pop_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              busy
);

  afifo_drain_state_e   state_r, state_n_s;
  logic [BUF_CNT_W-1:0] buf_cnt_s, drop_add_s;
  logic [DSIZE-1:0]     buf_head_s;
  logic                 buf_valid_s, hs_s, inc_s, push_s, clear_s;
  logic [CNT_W-1:0]     pop_cnt_r, drop_cnt_r;

  assign hs_s = buf_valid_s & m.m_ready;

  // next state, pop decode and drop accounting
  always_comb begin
    state_n_s  = state_r;
    inc_s      = 1'b0;
    push_s     = 1'b0;
    clear_s    = 1'b0;
    drop_add_s = {BUF_CNT_W{1'b0}};
    case (state_r)
      RUN: begin
        if (flush) begin
          // an entry handed off at this edge is delivered, not dropped
          clear_s    = 1'b1;
          drop_add_s = buf_cnt_s - {1'b0, hs_s};
          state_n_s  = FLUSH;
        end else begin
          inc_s  = !rd_empty && (buf_cnt_s < BUF_CNT_W'(DRAIN_BUF_DEPTH));
          push_s = inc_s;
        end
      end
      FLUSH: begin
        inc_s      = !rd_empty;
        drop_add_s = {1'b0, inc_s};
        if (rd_empty && !flush) begin
          state_n_s = RUN;
        end else begin
          state_n_s = FLUSH;
        end
      end
      default: begin
        state_n_s = RUN;
      end
    endcase
  end

  // state and counter registers
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      state_r    <= RUN;
      pop_cnt_r  <= {CNT_W{1'b0}};
      drop_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_n_s;
      pop_cnt_r  <= pop_cnt_r + CNT_W'(hs_s);
      drop_cnt_r <= drop_cnt_r + CNT_W'(drop_add_s);
    end
  end

  afifo_skid_buf #(.DSIZE(DSIZE)) u_buf (
    .clk       (rd_clk),
    .rst_n     (rd_rst),
    .push      (push_s),
    .push_data (rd_data),
    .pop       (hs_s),
    .clear     (clear_s),
    .valid     (buf_valid_s),
    .head      (buf_head_s),
    .count     (buf_cnt_s)
  );

  afifo_rd_drain_chk u_chk (
    .clk      (rd_clk),
    .rst_n    (rd_rst),
    .rd_inc   (rd_inc),
    .rd_empty (rd_empty)
  );

  // the pop strobe is forced low while reset is held
  assign rd_inc    = inc_s & rd_rst;
  assign m.m_valid = buf_valid_s;
  assign m.m_data  = buf_head_s;
  assign pop_cnt   = pop_cnt_r;
  assign drop_cnt  = drop_cnt_r;
  assign busy      = (state_r == FLUSH) || (buf_cnt_s != 2'd0);

endmodule
